seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. One `seven_seg_decoder` is shared across all digits. The controller holds a frame of hex nibbles, steps through the digits, and presents each nibble to the decoder while driving that digit's anode. It inserts an all-off guard interval between digits to suppress ghosting, and applies newly loaded data only at frame boundaries so the display never tears. It sits between the user/counter logic and the board's display pins.

---
 rtl/seven_seg_pkg.sv | 15 +
 rtl/seven_seg_decoder.sv | 40 ++++
 rtl/seven_seg_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller and its decoder.
// Holds the scan state encoding, the all-segments-off pattern and the digit widths.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GUARD = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam int         NIBBLE_W = 4;
   localparam int         SEG_W    = 7;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low {A,B,C,D,E,F,G} segment pattern; purely combinational.
// Zero latency, no handshake: the output follows x3..x0 within the same cycle.
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  logic             x3,
   input  logic             x2,
   input  logic             x1,
   input  logic             x0,
   output logic [SEG_W-1:0] seg_n
);

   logic [NIBBLE_W-1:0] nib;

   assign nib = {x3, x2, x1, x0};

   always_comb begin
      seg_n = SEG_OFF;
      case (nib)
         4'h0: seg_n = 7'h01;
         4'h1: seg_n = 7'h4F;
         4'h2: seg_n = 7'h12;
         4'h3: seg_n = 7'h06;
         4'h4: seg_n = 7'h4C;
         4'h5: seg_n = 7'h24;
         4'h6: seg_n = 7'h20;
         4'h7: seg_n = 7'h0F;
         4'h8: seg_n = 7'h00;
         4'h9: seg_n = 7'h04;
         4'hA: seg_n = 7'h08;
         4'hB: seg_n = 7'h60;
         4'hC: seg_n = 7'h31;
         4'hD: seg_n = 7'h42;
         4'hE: seg_n = 7'h30;
         4'hF: seg_n = 7'h38;
         default: seg_n = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode display scanner: GUARD/SHOW slots per digit, outputs one cycle behind state,
// loads shadowed until the frame boundary; SEVEN_SEG_LZ_BLANK_EN compiles in leading-zero blanking.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           load,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]          dp_in,
   output logic [NUM_DIGITS-1:0]          an_n,
   output logic [SEG_W-1:0]               seg_n,
   output logic                           dp_n,
   output logic                           frame_done,
   output logic                           load_pending
);

   localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   scan_state_t                              state_q, state_d;
   logic [IDX_W-1:0]                         idx_q, idx_d;
   logic [CNT_W-1:0]                         cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0][NIBBLE_W-1:0]      shd_data_q, shd_data_d, dsp_data_q, dsp_data_d;
   logic [NUM_DIGITS-1:0]                    shd_dp_q, shd_dp_d, dsp_dp_q, dsp_dp_d;
   logic                                     load_pending_q, load_pending_d;
   logic                                     frame_done_q, frame_done_d;
   logic [NUM_DIGITS-1:0]                    an_n_q, an_n_d;
   logic                                     dp_n_q, dp_n_d;
   logic                                     show_q, show_d;
   logic [NIBBLE_W-1:0]                      nib_q, nib_d;
   logic                                     guard_last, show_last, at_boundary;
   logic                                     digit_blank, lit;
   logic [SEG_W-1:0]                         dec_seg_n;

   assign guard_last  = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
   assign show_last   = (cnt_q == CNT_W'(PRESCALE - 1));
   assign at_boundary = (state_q == SHOW) && show_last && (idx_q == IDX_W'(NUM_DIGITS - 1)) && enable;

`ifdef SEVEN_SEG_LZ_BLANK_EN
   logic zero_run;

   // A digit is dark when it and every more-significant display nibble are zero.
   always_comb begin
      digit_blank = 1'b0;
      zero_run    = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run & (dsp_data_q[i] == '0);
         if (IDX_W'(i) == idx_q) digit_blank = zero_run;
      end
   end
`else
   assign digit_blank = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         cnt_q          <= '0;
         shd_data_q     <= '0;
         shd_dp_q       <= '0;
         dsp_data_q     <= '0;
         dsp_dp_q       <= '0;
         load_pending_q <= 1'b0;
         frame_done_q   <= 1'b0;
         an_n_q         <= '1;
         dp_n_q         <= 1'b1;
         show_q         <= 1'b0;
         nib_q          <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         shd_data_q     <= shd_data_d;
         shd_dp_q       <= shd_dp_d;
         dsp_data_q     <= dsp_data_d;
         dsp_dp_q       <= dsp_dp_d;
         load_pending_q <= load_pending_d;
         frame_done_q   <= frame_done_d;
         an_n_q         <= an_n_d;
         dp_n_q         <= dp_n_d;
         show_q         <= show_d;
         nib_q          <= nib_d;
      end
   end

   always_comb begin : next_state
      state_d        = state_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      shd_data_d     = shd_data_q;
      shd_dp_d       = shd_dp_q;
      dsp_data_d     = dsp_data_q;
      dsp_dp_d       = dsp_dp_q;
      load_pending_d = load_pending_q;
      frame_done_d   = at_boundary;

      if (!enable) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = GUARD;
               cnt_d   = '0;
            end
            GUARD: begin
               if (guard_last) begin
                  state_d = SHOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            SHOW: begin
               if (show_last) begin
                  state_d = GUARD;
                  cnt_d   = '0;
                  idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end

      if (load) begin
         shd_data_d = data_in;
         shd_dp_d   = dp_in;
      end

      // A load landing on the boundary, or while idle, bypasses the shadow stage.
      if (at_boundary) begin
         dsp_data_d     = load ? data_in : shd_data_q;
         dsp_dp_d       = load ? dp_in   : shd_dp_q;
         load_pending_d = 1'b0;
      end else if (load) begin
         if (state_q == IDLE) begin
            dsp_data_d     = data_in;
            dsp_dp_d       = dp_in;
            load_pending_d = 1'b0;
         end else begin
            load_pending_d = 1'b1;
         end
      end
   end

   always_comb begin : outputs
      show_d = (state_q == SHOW) && enable;
      lit    = show_d && !digit_blank;
      an_n_d = '1;
      if (lit) an_n_d[idx_q] = 1'b0;
      dp_n_d = lit ? ~dsp_dp_q[idx_q] : 1'b1;
      nib_d  = dsp_data_q[idx_q];
   end

   seven_seg_decoder u_dec (
      .x3    (nib_q[3]),
      .x2    (nib_q[2]),
      .x1    (nib_q[1]),
      .x0    (nib_q[0]),
      .seg_n (dec_seg_n)
   );

   assign an_n         = an_n_q;
   assign seg_n        = show_q ? dec_seg_n : SEG_OFF;
   assign dp_n         = dp_n_q;
   assign frame_done   = frame_done_q;
   assign load_pending = load_pending_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with 4 digits, 4-cycle SHOW and 2-cycle GUARD slots.
// Expected outputs come from frame-position arithmetic and a load/shadow bookkeeping of the data.
module tb_seven_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int PS    = 4;
   localparam int BC    = 2;
   localparam int SLOT  = BC + PS;
   localparam int FRAME = ND * SLOT;

   logic        clk = 1'b0;
   logic        reset, enable, load;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n, frame_done, load_pending;

   typedef struct {
      logic [3:0] an_n;
      logic [6:0] seg_n;
      logic       dp_n;
      logic       fd;
      logic       lp;
   } exp_t;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dp;
      logic [27:0] segs;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .load         (load),
      .data_in      (data_in),
      .dp_in        (dp_in),
      .an_n         (an_n),
      .seg_n        (seg_n),
      .dp_n         (dp_n),
      .frame_done   (frame_done),
      .load_pending (load_pending)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
         4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
         4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
         4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
      endcase
   endfunction

   function automatic logic [27:0] segs_of(input logic [15:0] v);
      logic [27:0] r;
      for (int i = 0; i < ND; i++) r[7*i +: 7] = hex7(v[4*i +: 4]);
      return r;
   endfunction

   function automatic exp_t off_exp(input logic lp);
      exp_t e;
      e.an_n  = 4'hF;
      e.seg_n = 7'h7F;
      e.dp_n  = 1'b1;
      e.fd    = 1'b0;
      e.lp    = lp;
      return e;
   endfunction

   // Sample j counts edges since the enabling edge; sample j shows frame position j-1.
   function automatic exp_t scan_exp(input int j, input logic [15:0] val, input logic [3:0] dp,
                                     input logic [27:0] segs, input logic lp);
      exp_t e;
      int   pos, d, w;
      logic show, lit;
      e = off_exp(lp);
      if (j < 1) return e;
      pos  = (j - 1) % FRAME;
      d    = pos / SLOT;
      w    = pos % SLOT;
      show = (w >= BC);
      lit  = show;
`ifdef SEVEN_SEG_LZ_BLANK_EN
      if (d >= 1 && (val >> (4 * d)) == 16'h0) lit = 1'b0;
`endif
      if (show) e.seg_n = segs[7*d +: 7];
      if (lit) begin
         e.an_n = ~(4'b0001 << d);
         e.dp_n = ~dp[d];
      end
      e.fd = (pos == FRAME - 1);
      return e;
   endfunction

   task automatic step(input logic rs, input logic en, input logic ld, input logic [15:0] d,
                       input logic [3:0] dpi, input exp_t e, input string nm, input int j);
      exp_t x;
      reset   = rs;
      enable  = en;
      load    = ld;
      data_in = d;
      dp_in   = dpi;
      sb.push_back(e);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      n_cmp++;
      if ({an_n, seg_n, dp_n, frame_done, load_pending} !== {x.an_n, x.seg_n, x.dp_n, x.fd, x.lp}) begin
         n_bad++;
         $display("FAIL %s j=%0d got an_n=%b seg_n=%h dp_n=%b fd=%b lp=%b want an_n=%b seg_n=%h dp_n=%b fd=%b lp=%b",
                  nm, j, an_n, seg_n, dp_n, frame_done, load_pending,
                  x.an_n, x.seg_n, x.dp_n, x.fd, x.lp);
      end
   endtask

   initial begin
      vec_t        vt[4];
      logic        ld, pend;
      logic [15:0] ldv, sh, disp;
      exp_t        e;

      vt[0] = '{data: 16'h3210, dp: 4'b0001, segs: {7'h06, 7'h12, 7'h4F, 7'h01}};
      vt[1] = '{data: 16'h7654, dp: 4'b0010, segs: {7'h0F, 7'h20, 7'h24, 7'h4C}};
      vt[2] = '{data: 16'hBA98, dp: 4'b0100, segs: {7'h60, 7'h08, 7'h04, 7'h00}};
      vt[3] = '{data: 16'hFEDC, dp: 4'b1111, segs: {7'h38, 7'h30, 7'h42, 7'h31}};

      // Reset and idle: dark display, no pulses.
      for (int i = 0; i < 2; i++)  step(1, 0, 0, 16'h0, 4'h0, off_exp(0), "reset", i);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0, 4'h0, off_exp(0), "idle", i);

      // Glyph and dp table, one full frame each.
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 1, vt[k].data, vt[k].dp, off_exp(0), "tbl_start", 0);
         for (int j = 1; j <= FRAME; j++)
            step(0, 1, 0, 16'h0, 4'h0, scan_exp(j, vt[k].data, vt[k].dp, vt[k].segs, 0), "tbl_scan", j);
         step(0, 0, 0, 16'h0, 4'h0, off_exp(0), "tbl_stop", FRAME + 1);
      end

      // Long run: mid-frame load, boundary load, double load, then enable drop in digit 2.
      step(0, 1, 1, 16'h1234, 4'h0, off_exp(0), "run_start", 0);
      disp = 16'h1234;
      sh   = 16'h1234;
      pend = 1'b0;
      for (int j = 1; j <= 160; j++) begin
         ld  = 1'b0;
         ldv = 16'h0;
         case (j)
            30:  begin ld = 1'b1; ldv = 16'hABCD; end
            96:  begin ld = 1'b1; ldv = 16'h0F00; end
            100: begin ld = 1'b1; ldv = 16'h1111; end
            110: begin ld = 1'b1; ldv = 16'h2222; end
            default: ;
         endcase
         e = scan_exp(j, disp, 4'h0, segs_of(disp), 1'b0);
         if (j % FRAME == 0) begin
            disp = ld ? ldv : sh;
            pend = 1'b0;
         end else if (ld) begin
            pend = 1'b1;
         end
         if (ld) sh = ldv;
         e.lp = pend;
         if (j == 160) step(0, 0, 0, 16'h0, 4'h0, off_exp(pend), "drop_en", j);
         else          step(0, 1, ld, ldv, 4'h0, e, "run", j);
      end
      step(0, 0, 0, 16'h0, 4'h0, off_exp(0), "idle_after_drop", 161);

      // Restart from digit 0, then reset in the middle of digit 1's SHOW with a pending load.
      step(0, 1, 0, 16'h0, 4'h0, off_exp(0), "reen_start", 0);
      for (int j = 1; j <= 9; j++)
         step(0, 1, (j == 5), 16'h9999, 4'h0,
              scan_exp(j, 16'h2222, 4'h0, segs_of(16'h2222), (j >= 5)), "reen_scan", j);
      step(1, 1, 1, 16'hFFFF, 4'hF, off_exp(0), "reset_mid_show", 10);
      for (int i = 0; i < 2; i++) step(0, 0, 0, 16'h0, 4'h0, off_exp(0), "post_rst_idle", i);
      step(0, 1, 0, 16'h0, 4'h0, off_exp(0), "post_rst_start", 0);
      for (int j = 1; j <= FRAME; j++)
         step(0, 1, 0, 16'h0, 4'h0, scan_exp(j, 16'h0, 4'h0, segs_of(16'h0), 0), "post_rst_scan", j);
      step(0, 0, 0, 16'h0, 4'h0, off_exp(0), "post_rst_stop", FRAME + 1);

      // Leading zeros with a decimal point requested on the top digit.
      step(0, 1, 1, 16'h0050, 4'b1000, off_exp(0), "lz_start", 0);
      for (int j = 1; j <= FRAME; j++)
         step(0, 1, 0, 16'h0, 4'h0, scan_exp(j, 16'h0050, 4'b1000, segs_of(16'h0050), 0), "lz_scan", j);
      step(0, 0, 0, 16'h0, 4'h0, off_exp(0), "lz_stop", FRAME + 1);

      load = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
